gpr_bank: RTL and testbench

Parametrised successor to the single general-purpose register: a bank of NREG registers of WIDTH bits, written from the S bus and read onto two buses (A and B).
- Per-register one-hot store and read-select lines, matching the existing SRx/RxA control style.
- Adds in-place increment/decrement, a one-level shadow snapshot (save/restore) and registered status flags.
- Sits between the control unit (select/op lines) and the ALU bus network.

---
 rtl/gpr_bank.sv | 109 ++++++++++
 tb/tb_gpr_bank.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/gpr_bank.sv
// Bank of NREG general-purpose registers with one-hot store/read selects,
// in-place increment/decrement, a one-level shadow snapshot and status flags.
module gpr_bank #(
  parameter int WIDTH = 16,
  parameter int NREG = 8,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  CLK,
  input  logic                  CLR,
  input  logic [NREG-1:0]       SR,
  input  logic [1:0]            OP,
  input  logic [WIDTH-1:0]      S_bus,
  input  logic [NREG-1:0]       RA,
  input  logic [NREG-1:0]       RB,
  input  logic                  SAVE,
  input  logic                  RESTORE,
  output logic [WIDTH-1:0]      A_bus,
  output logic [WIDTH-1:0]      B_bus,
  output logic [NREG*WIDTH-1:0] reg_values,
  output logic                  zero_flag,
  output logic                  wrap_flag,
  output logic                  shadow_valid
);

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_HOLD = 2'b11;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] regs   [NREG];
  logic [WIDTH-1:0] shadow [NREG];
  logic [WIDTH-1:0] nxt    [NREG];

  logic restore_eff;
  logic write_cycle;
  logic wrap_any;
  logic zero_nxt;
  logic found;

  // A restore with no snapshot behind it is treated as if it never happened.
  assign restore_eff = RESTORE & shadow_valid;
  assign write_cycle = ~restore_eff & (|SR) & (OP != OP_HOLD);

  always_comb begin
    wrap_any = 1'b0;
    zero_nxt = 1'b0;
    found    = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      case (OP)
        OP_LOAD: nxt[i] = S_bus;
        OP_INC:  nxt[i] = regs[i] + ONE;
        OP_DEC:  nxt[i] = regs[i] - ONE;
        default: nxt[i] = regs[i];
      endcase
      if (SR[i]) begin
        if ((OP == OP_INC && regs[i] == '1) || (OP == OP_DEC && regs[i] == '0))
          wrap_any = 1'b1;
        // Zero status reports only the lowest-index selected register.
        if (!found) begin
          zero_nxt = (nxt[i] == '0);
          found    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    A_bus      = '0;
    B_bus      = '0;
    reg_values = '0;
    for (int i = 0; i < NREG; i++) begin
      if (RA[i]) A_bus = A_bus | regs[i];
      if (RB[i]) B_bus = B_bus | regs[i];
      reg_values[i*WIDTH +: WIDTH] = regs[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i]   <= INIT_VALUE;
        shadow[i] <= INIT_VALUE;
      end
      zero_flag    <= 1'b0;
      wrap_flag    <= 1'b0;
      shadow_valid <= 1'b0;
    end else begin
      if (restore_eff) begin
        for (int i = 0; i < NREG; i++) regs[i] <= shadow[i];
      end else begin
        for (int i = 0; i < NREG; i++) begin
          if (SR[i]) regs[i] <= nxt[i];
        end
        // Snapshot takes pre-edge values even when a write lands this cycle.
        if (SAVE) begin
          for (int i = 0; i < NREG; i++) shadow[i] <= regs[i];
          shadow_valid <= 1'b1;
        end
      end
      if (write_cycle) begin
        zero_flag <= zero_nxt;
        wrap_flag <= wrap_any;
      end
    end
  end

endmodule

// File: tb/tb_gpr_bank.sv
// Self-checking bench for gpr_bank: vector table, hand-written save/restore
// and reset sequences, and a randomized phase against a small reference model.
module tb_gpr_bank;

  localparam int W = 16;
  localparam int N = 8;

  logic           clk;
  logic           clr;
  logic [N-1:0]   sr;
  logic [1:0]     op;
  logic [W-1:0]   s_bus;
  logic [N-1:0]   ra;
  logic [N-1:0]   rb;
  logic           save;
  logic           restore;
  logic [W-1:0]   a_bus;
  logic [W-1:0]   b_bus;
  logic [N*W-1:0] reg_values;
  logic           zero_flag;
  logic           wrap_flag;
  logic           shadow_valid;

  gpr_bank #(.WIDTH(W), .NREG(N), .INIT_VALUE('0)) dut (
    .CLK(clk), .CLR(clr), .SR(sr), .OP(op), .S_bus(s_bus),
    .RA(ra), .RB(rb), .SAVE(save), .RESTORE(restore),
    .A_bus(a_bus), .B_bus(b_bus), .reg_values(reg_values),
    .zero_flag(zero_flag), .wrap_flag(wrap_flag), .shadow_valid(shadow_valid)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         clr;
    logic [N-1:0] sr;
    logic [1:0]   op;
    logic [W-1:0] s;
    logic [N-1:0] ra;
    logic [N-1:0] rb;
    logic         save;
    logic         restore;
    logic [W-1:0] exp_a;
    logic [W-1:0] exp_b;
    logic         exp_z;
    logic         exp_w;
    logic         exp_sv;
  } vec_t;

  localparam int EW = 2*W + 3;
  logic [EW-1:0] exp_q[$];

  int n_cmp  = 0;
  int n_fail = 0;

  vec_t tbl [16];
  logic [W-1:0] m [N];
  logic m_z, m_w;

  function automatic vec_t mk(input logic c, input logic [N-1:0] s_r, input logic [1:0] o,
                              input logic [W-1:0] d, input logic [N-1:0] a_s, input logic [N-1:0] b_s,
                              input logic sv_in, input logic rs_in,
                              input logic [W-1:0] ea, input logic [W-1:0] eb,
                              input logic ez, input logic ew, input logic esv);
    vec_t v;
    v.clr = c; v.sr = s_r; v.op = o; v.s = d; v.ra = a_s; v.rb = b_s;
    v.save = sv_in; v.restore = rs_in;
    v.exp_a = ea; v.exp_b = eb; v.exp_z = ez; v.exp_w = ew; v.exp_sv = esv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_wide(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: inputs change on the falling edge, outputs sampled 1ns after the rising edge
  task automatic apply(input vec_t v, input string tag);
    logic [EW-1:0] e;
    @(negedge clk);
    clr = v.clr; sr = v.sr; op = v.op; s_bus = v.s;
    ra = v.ra; rb = v.rb; save = v.save; restore = v.restore;
    exp_q.push_back({v.exp_a, v.exp_b, v.exp_z, v.exp_w, v.exp_sv});
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk({tag, " queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, " a_bus"},        {16'h0, a_bus},        {16'h0, e[EW-1 -: W]});
      chk({tag, " b_bus"},        {16'h0, b_bus},        {16'h0, e[W+2 -: W]});
      chk({tag, " zero_flag"},    {31'h0, zero_flag},    {31'h0, e[2]});
      chk({tag, " wrap_flag"},    {31'h0, wrap_flag},    {31'h0, e[1]});
      chk({tag, " shadow_valid"}, {31'h0, shadow_valid}, {31'h0, e[0]});
    end
  endtask

  function automatic logic [N*W-1:0] model_vec();
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*W +: W] = m[i];
    return r;
  endfunction

  initial begin
    logic [N*W-1:0] ev;
    vec_t v;
    clr = 1'b1; sr = '0; op = 2'b11; s_bus = '0; ra = '0; rb = '0; save = 1'b0; restore = 1'b0;

    //             clr sr     op     s        ra     rb     sv rs  exp_a    exp_b    z  w  sv
    tbl[0]  = mk(1, 8'h00, 2'b00, 16'h0000, 8'hFF, 8'hFF, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
    tbl[1]  = mk(0, 8'h04, 2'b00, 16'hBEEF, 8'h04, 8'h00, 0, 0, 16'hBEEF, 16'h0000, 0, 0, 0);
    tbl[2]  = mk(0, 8'h00, 2'b11, 16'h0000, 8'h04, 8'h04, 0, 0, 16'hBEEF, 16'hBEEF, 0, 0, 0);
    tbl[3]  = mk(0, 8'h02, 2'b00, 16'hFFFF, 8'h02, 8'h04, 0, 0, 16'hFFFF, 16'hBEEF, 0, 0, 0);
    tbl[4]  = mk(0, 8'h02, 2'b01, 16'h0000, 8'h02, 8'h00, 0, 0, 16'h0000, 16'h0000, 1, 1, 0);
    tbl[5]  = mk(0, 8'h02, 2'b10, 16'h0000, 8'h02, 8'h00, 0, 0, 16'hFFFF, 16'h0000, 0, 1, 0);
    tbl[6]  = mk(0, 8'h02, 2'b11, 16'h0000, 8'h02, 8'h00, 0, 0, 16'hFFFF, 16'h0000, 0, 1, 0);
    tbl[7]  = mk(0, 8'h00, 2'b00, 16'h1234, 8'h02, 8'h00, 0, 0, 16'hFFFF, 16'h0000, 0, 1, 0);
    tbl[8]  = mk(0, 8'h02, 2'b00, 16'h0000, 8'h02, 8'h00, 0, 0, 16'h0000, 16'h0000, 1, 0, 0);
    tbl[9]  = mk(0, 8'h01, 2'b00, 16'h00F0, 8'h01, 8'h00, 0, 0, 16'h00F0, 16'h0000, 0, 0, 0);
    tbl[10] = mk(0, 8'h08, 2'b00, 16'h0F00, 8'h08, 8'h01, 0, 0, 16'h0F00, 16'h00F0, 0, 0, 0);
    tbl[11] = mk(0, 8'h00, 2'b11, 16'h0000, 8'h09, 8'h00, 0, 0, 16'h0FF0, 16'h0000, 0, 0, 0);
    tbl[12] = mk(0, 8'h09, 2'b01, 16'h0000, 8'h01, 8'h08, 0, 0, 16'h00F1, 16'h0F01, 0, 0, 0);
    tbl[13] = mk(0, 8'h0A, 2'b10, 16'h0000, 8'h02, 8'h08, 0, 0, 16'hFFFF, 16'h0F00, 0, 1, 0);
    tbl[14] = mk(0, 8'h0A, 2'b01, 16'h0000, 8'h02, 8'h08, 0, 0, 16'h0000, 16'h0F01, 1, 1, 0);
    tbl[15] = mk(0, 8'h09, 2'b10, 16'h0000, 8'h09, 8'h00, 0, 0, 16'h0FF0, 16'h0000, 0, 0, 0);

    for (int k = 0; k < 16; k++) apply(tbl[k], $sformatf("vec%0d", k));

    // RESTORE with no snapshot behaves as a plain write
    apply(mk(0, 8'h01, 2'b00, 16'h0042, 8'h01, 8'h00, 0, 1, 16'h0042, 16'h0000, 0, 0, 0), "norestore");
    ev = '0;
    ev[0*W +: W] = 16'h0042; ev[1*W +: W] = 16'h0000; ev[2*W +: W] = 16'hBEEF; ev[3*W +: W] = 16'h0F00;
    chk_wide("regs_after_norestore", reg_values, ev);

    // save with a concurrent write, then repeated restore
    apply(mk(0, 8'h20, 2'b00, 16'h1234, 8'h20, 8'h00, 0, 0, 16'h1234, 16'h0000, 0, 0, 0), "load_r5");
    apply(mk(0, 8'h20, 2'b00, 16'h5678, 8'h20, 8'h00, 1, 0, 16'h5678, 16'h0000, 0, 0, 1), "save_write");
    apply(mk(0, 8'h80, 2'b00, 16'h0000, 8'h80, 8'h20, 0, 0, 16'h0000, 16'h5678, 1, 0, 1), "zero_r7");
    apply(mk(0, 8'h20, 2'b00, 16'h9999, 8'h20, 8'h01, 1, 1, 16'h1234, 16'h0042, 1, 0, 1), "restore1");
    apply(mk(0, 8'h20, 2'b01, 16'h0000, 8'h20, 8'h04, 0, 1, 16'h1234, 16'hBEEF, 1, 0, 1), "restore2");
    ev[5*W +: W] = 16'h1234;
    chk_wide("regs_after_restore", reg_values, ev);

    // reset overrides a simultaneous write, save and restore
    apply(mk(1, 8'hFF, 2'b00, 16'hAAAA, 8'hFF, 8'hFF, 1, 1, 16'h0000, 16'h0000, 0, 0, 0), "clr_mid");
    chk_wide("regs_after_clr", reg_values, '0);
    apply(mk(0, 8'h00, 2'b11, 16'h0000, 8'hFF, 8'h00, 0, 1, 16'h0000, 16'h0000, 0, 0, 0), "restore_after_clr");
    apply(mk(0, 8'h04, 2'b00, 16'hBEEF, 8'h04, 8'h00, 0, 0, 16'hBEEF, 16'h0000, 0, 0, 0), "load_r2");
    ev = '0;
    ev[2*W +: W] = 16'hBEEF;
    chk_wide("regs_slot2_only", reg_values, ev);

    // randomized writes and reads against a reference model
    for (int i = 0; i < N; i++) m[i] = '0;
    m[2] = 16'hBEEF;
    m_z = 1'b0; m_w = 1'b0;
    for (int k = 0; k < 60; k++) begin
      logic [W-1:0] nv;
      logic first;
      logic wr;
      v = mk(0, N'($urandom_range(0, 255)), 2'($urandom_range(0, 3)), W'($urandom),
             N'($urandom_range(0, 255)), N'($urandom_range(0, 255)), 0, 0, '0, '0, 0, 0, 0);
      // bias toward boundary values so wraps occur
      if ($urandom_range(0, 3) == 0) v.s = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'h0000;
      wr = (v.sr != 0) && (v.op != 2'b11);
      first = 1'b1;
      if (wr) m_w = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (v.sr[i] && wr) begin
          if (v.op == 2'b00) nv = v.s;
          else if (v.op == 2'b01) begin
            nv = m[i] + 16'd1;
            if (m[i] == 16'hFFFF) m_w = 1'b1;
          end else begin
            nv = m[i] - 16'd1;
            if (m[i] == 16'h0000) m_w = 1'b1;
          end
          if (first) m_z = (nv == 16'h0000);
          first = 1'b0;
          m[i] = nv;
        end
      end
      v.exp_a = '0; v.exp_b = '0;
      for (int i = 0; i < N; i++) begin
        if (v.ra[i]) v.exp_a = v.exp_a | m[i];
        if (v.rb[i]) v.exp_b = v.exp_b | m[i];
      end
      v.exp_z = m_z; v.exp_w = m_w; v.exp_sv = 1'b0;
      apply(v, $sformatf("rnd%0d", k));
    end
    chk_wide("regs_after_random", reg_values, model_vec());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
